uart_rx_ext: RTL and testbench
==============================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, default 868, clk cycles per bit; legal values are 8 to 65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal values are 5 to 9.
REQ-003 SHALL have parameter PARITY, default PAR_NONE, one of PAR_NONE / PAR_EVEN / PAR_ODD.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values are 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; must be a power of 2 and at least 2.
REQ-006 SHALL have port clk, input, 1 bit: the only clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port data_o, output, DATA_BITS bits: FIFO head data.
REQ-010 SHALL have port valid_o, output, 1 bit: FIFO head valid.
REQ-011 SHALL have port ready_i, input, 1 bit: consumer accepts the head when valid_o and ready_i are both high.
REQ-012 SHALL have port parity_err_o, output, 1 bit: parity error flag of the head entry.
REQ-013 SHALL have port frame_err_o, output, 1 bit: framing error flag of the head entry.
REQ-014 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when a frame is dropped because the FIFO is full.
REQ-015 SHALL have port break_o, output, 1 bit: one-cycle pulse when a break is detected.

Function
REQ-016 SHALL synchronise rx through 2 flip-flops; both flops reset to 1.
REQ-017 SHALL, in IDLE, enter START when the synchronised rx is 0, loading the baud counter so the first sample lands at CLOCKS_PER_BAUD/2.
REQ-018 SHALL take each bit as the majority of 3 synchronised samples at bit-centre -1, 0 and +1 clocks.
REQ-019 SHALL return to IDLE with no FIFO push and no flag if the start-bit majority is 1 (false start or glitch).
REQ-020 SHALL step through states IDLE -> START -> DATA (DATA_BITS bits, LSB first) -> PARITY (only when PARITY != PAR_NONE) -> STOP (STOP_BITS bits) -> IDLE.
REQ-021 SHALL set the parity error when the received parity bit mismatches: even = XOR of data and parity bits must be 0; odd = that XOR must be 1.
REQ-022 SHALL set the frame error when any checked stop bit samples 0.
REQ-023 SHALL treat a frame whose data, parity and stop bits all sample 0 as a break: pulse break_o for one cycle, do not push, enter BREAK_WAIT.
REQ-024 SHALL leave BREAK_WAIT for IDLE only after the synchronised rx has been 1 for one full CLOCKS_PER_BAUD.
REQ-025 SHALL push {frame_err, parity_err, data} into the FIFO in the cycle after the last stop-bit majority is resolved.
REQ-026 SHALL push a frame with a frame or parity error like any other frame, with its flags attached.
REQ-027 SHALL use first-word-fall-through output ordering; valid_o rises 1 cycle after a push into an empty FIFO.
REQ-028 SHALL drive data_o, parity_err_o and frame_err_o from the same entry as valid_o.
REQ-029 SHALL, when a push arrives with the FIFO full and no pop in the same cycle, drop the new frame, pulse overrun_o for 1 cycle and leave stored contents unchanged.
REQ-030 SHALL, when push and pop coincide on a full FIFO, accept the push; no overrun.
REQ-031 SHALL, when push and pop coincide on an empty FIFO, write the entry and set valid_o the next cycle.
REQ-032 SHALL allow a new START to be detected in the cycle immediately after the STOP sample, supporting back-to-back frames.
REQ-033 SHALL size the baud counter as $clog2(CLOCKS_PER_BAUD) bits; counter arithmetic must not wrap within a bit period.

Reset
REQ-034 SHALL on rst force state IDLE, counters 0, FIFO empty, valid_o 0, all flags and pulses 0, data_o 0.
REQ-035 SHALL abandon a frame in progress on rst with no push; the first frame after rst release is received normally.

Structure
REQ-036 SHALL take the parity enum (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2) and the state enum from shared package uart_pkg.
REQ-037 SHALL instantiate the FIFO as sub-module sync_fifo, parametrised by WIDTH=DATA_BITS+2 and DEPTH=FIFO_DEPTH.

Verification (CLOCKS_PER_BAUD=16, 8 data bits, 1 stop bit unless stated)
REQ-038 SHALL cover: frame 0xA5, PARITY=PAR_NONE, ready_i=1 -> data_o=0xA5, valid_o high 1 cycle, no flags.
REQ-039 SHALL cover: PARITY=PAR_EVEN, 0x3C sent with parity bit 1 -> data_o=0x3C, parity_err_o=1; same frame with parity bit 0 -> parity_err_o=0.
REQ-040 SHALL cover: 0x55 sent with stop bit 0 -> frame_err_o=1, data_o=0x55; a 3-cycle low glitch on an idle line -> no push.
REQ-041 SHALL cover: rx held low for 12 bit times then released -> break_o pulses exactly once, no push, next frame 0x81 received correctly.
REQ-042 SHALL cover: FIFO_DEPTH=4, ready_i=0, frames 0x01 to 0x05 sent -> overrun_o pulses on frame 5; draining yields 0x01, 0x02, 0x03, 0x04 in order.
REQ-043 SHALL cover: rst asserted at mid-DATA of 0x7E -> no push; frame 0x42 sent after release -> data_o=0x42.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity selection, receiver
// state encoding and the 3-sample majority vote.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK_WAIT
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO holding received frames with their flags.
// Head outputs read as zero while empty; overrun pulses when a push is lost.
module sync_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             valid,
   output logic             overrun
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign valid     = (count != '0);
   assign full      = (count == (AW+1)'(DEPTH));
   assign do_pop    = pop & valid;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign do_push   = push & (~full | do_pop);
   assign head_data = valid ? mem[rd_ptr] : '0;

   // storage write; contents are only observable through the valid-gated head
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // pointer, occupancy and overrun pulse bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         overrun <= push & full & ~do_pop;
      end
   end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with 3-sample majority voting, optional parity, 1 or 2
// stop bits, break detection and a FWFT receive FIFO.
module uart_rx_ext
   import uart_pkg::*;
#(
   parameter int unsigned CLOCKS_PER_BAUD = 868,
   parameter int unsigned DATA_BITS       = 8,
   parameter parity_t     PARITY          = PAR_NONE,
   parameter int unsigned STOP_BITS       = 1,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 overrun_o,
   output logic                 break_o
);

   localparam int unsigned CW    = $clog2(CLOCKS_PER_BAUD);
   localparam int unsigned WIDTH = DATA_BITS + 2;

   localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCKS_PER_BAUD / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_BAUD - 1);
   localparam logic [CW-1:0] ONE       = CW'(1);
   localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   logic                 rx_meta;
   logic                 rx_sync;
   state_t               state;
   logic [CW-1:0]        cnt;
   logic                 pend;
   logic                 s_a;
   logic                 s_b;
   logic                 bit_v;
   logic [3:0]           bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err;
   logic                 frm_err;
   logic                 all_zero;
   logic                 push;
   logic [WIDTH-1:0]     push_word;
   logic                 brk;
   logic [WIDTH-1:0]     head;

   // third sample is the live synchroniser output one clock after centre
   assign bit_v = maj3(s_a, s_b, rx_sync);

   // two-flop synchroniser, idles high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // receive state machine: bit timing, sampling, frame assembly and checks.
   // Samples land at cnt==1 and cnt==0; the counter reloads at centre so the
   // resolving cycle (pend) is centre+1 and the next centre is one period on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         pend      <= 1'b0;
         s_a       <= 1'b0;
         s_b       <= 1'b0;
         bit_cnt   <= '0;
         stop_cnt  <= 1'b0;
         shreg     <= '0;
         par_err   <= 1'b0;
         frm_err   <= 1'b0;
         all_zero  <= 1'b0;
         push      <= 1'b0;
         push_word <= '0;
         brk       <= 1'b0;
      end else begin
         push <= 1'b0;
         brk  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rx_sync) begin
                  state <= ST_START;
                  cnt   <= HALF_LOAD;
                  pend  <= 1'b0;
               end
            end
            ST_BREAK_WAIT: begin
               if (!rx_sync)        cnt   <= FULL_LOAD;
               else if (cnt == '0)  state <= ST_IDLE;
               else                 cnt   <= cnt - ONE;
            end
            default: begin
               if (cnt == '0) begin
                  cnt  <= FULL_LOAD;
                  s_b  <= rx_sync;
                  pend <= 1'b1;
               end else begin
                  cnt <= cnt - ONE;
                  if (cnt == ONE) s_a <= rx_sync;
               end
               if (pend) begin
                  pend <= 1'b0;
                  case (state)
                     ST_START: begin
                        if (bit_v) begin
                           state <= ST_IDLE;
                        end else begin
                           state    <= ST_DATA;
                           bit_cnt  <= '0;
                           par_err  <= 1'b0;
                           frm_err  <= 1'b0;
                           all_zero <= 1'b1;
                        end
                     end
                     ST_DATA: begin
                        shreg    <= {bit_v, shreg[DATA_BITS-1:1]};
                        all_zero <= all_zero & ~bit_v;
                        if (bit_cnt == LAST_BIT) begin
                           stop_cnt <= 1'b0;
                           state    <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                           bit_cnt <= bit_cnt + 4'd1;
                        end
                     end
                     ST_PARITY: begin
                        par_err  <= (PARITY == PAR_ODD) ? ~(^shreg ^ bit_v)
                                                        :  (^shreg ^ bit_v);
                        all_zero <= all_zero & ~bit_v;
                        state    <= ST_STOP;
                     end
                     ST_STOP: begin
                        frm_err  <= frm_err | ~bit_v;
                        all_zero <= all_zero & ~bit_v;
                        if (stop_cnt == LAST_STOP) begin
                           if (all_zero & ~bit_v) begin
                              brk   <= 1'b1;
                              state <= ST_BREAK_WAIT;
                              cnt   <= FULL_LOAD;
                           end else begin
                              push      <= 1'b1;
                              push_word <= {frm_err | ~bit_v, par_err, shreg};
                              state     <= ST_IDLE;
                           end
                        end else begin
                           stop_cnt <= stop_cnt + 1'b1;
                        end
                     end
                     default: state <= ST_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   sync_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_data(push_word),
      .pop      (ready_i),
      .head_data(head),
      .valid    (valid_o),
      .overrun  (overrun_o)
   );

   assign {frame_err_o, parity_err_o, data_o} = head;
   assign break_o = brk;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: one receiver without parity, one with even parity.
module tb_uart_rx_ext;
   import uart_pkg::*;

   localparam int unsigned CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_n = 1'b1, rx_e = 1'b1;
   logic       ready_n = 1'b0, ready_e = 1'b0;
   logic [7:0] data_n, data_e;
   logic       valid_n, valid_e, pe_n, pe_e, fe_n, fe_e;
   logic       ovr_n, ovr_e, brk_n, brk_e;

   int n_cmp = 0;
   int n_bad = 0;
   int brk_cnt_n = 0, brk_cnt_e = 0, ovr_cnt_n = 0, vcyc_n = 0;
   logic [9:0] got_n[$];
   logic [9:0] got_e[$];
   logic [9:0] exp_e[$];

   always #5 clk = ~clk;

   uart_rx_ext #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(PAR_NONE),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
      .clk(clk), .rst(rst), .rx(rx_n), .data_o(data_n), .valid_o(valid_n),
      .ready_i(ready_n), .parity_err_o(pe_n), .frame_err_o(fe_n),
      .overrun_o(ovr_n), .break_o(brk_n));

   uart_rx_ext #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
      .clk(clk), .rst(rst), .rx(rx_e), .data_o(data_e), .valid_o(valid_e),
      .ready_i(ready_e), .parity_err_o(pe_e), .frame_err_o(fe_e),
      .overrun_o(ovr_e), .break_o(brk_e));

   // observe handshakes and pulses away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (valid_n && ready_n) got_n.push_back({fe_n, pe_n, data_n});
         if (valid_e && ready_e) got_e.push_back({fe_e, pe_e, data_e});
         if (valid_n) vcyc_n++;
         if (brk_n) brk_cnt_n++;
         if (brk_e) brk_cnt_e++;
         if (ovr_n) ovr_cnt_n++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_rx(input int d, input logic v);
      if (d == 0) rx_n = v;
      else        rx_e = v;
   endtask

   // full frame followed by two idle bit times
   task automatic send_frame(input int d, input logic [7:0] data, input bit has_par,
                             input logic par, input logic stop);
      set_rx(d, 1'b0); wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         set_rx(d, data[i]); wait_cyc(CPB);
      end
      if (has_par) begin
         set_rx(d, par); wait_cyc(CPB);
      end
      set_rx(d, stop); wait_cyc(CPB);
      set_rx(d, 1'b1); wait_cyc(2 * CPB);
   endtask

   task automatic pop_check(input int d, input string tag, input logic [9:0] exp);
      int sz;
      sz = (d == 0) ? got_n.size() : got_e.size();
      chk({tag, "_present"}, (sz > 0), 1);
      if (sz > 0) begin
         if (d == 0) chk(tag, got_n.pop_front(), exp);
         else        chk(tag, got_e.pop_front(), exp);
      end
   endtask

   // reference: {frame_err, parity_err, data} from the frame-level rules
   function automatic logic [9:0] model_word(input logic [7:0] d, input bit has_par,
                                             input logic p, input logic stop);
      logic pe;
      pe = has_par && ((($countones(d) + int'(p)) % 2) == 1);
      return {~stop, pe, d};
   endfunction

   function automatic bit model_break(input logic [7:0] d, input bit has_par,
                                      input logic p, input logic stop);
      return (d == 8'h00) && (!has_par || p == 1'b0) && (stop == 1'b0);
   endfunction

   initial begin
      int v0, b0, o0, brk_exp;
      logic [7:0] rd;
      logic rp, rs;

      wait_cyc(4);
      // reset state
      chk("rst_valid", valid_n, 0);
      chk("rst_data", data_n, 0);
      chk("rst_flags", {pe_n, fe_n, ovr_n, brk_n}, 0);
      rst = 1'b0;
      wait_cyc(4);
      chk("post_rst_valid", {valid_n, valid_e}, 0);

      // plain frame, consumer always ready
      ready_n = 1'b1; ready_e = 1'b1;
      v0 = vcyc_n;
      send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
      pop_check(0, "a5", model_word(8'hA5, 0, 1'b0, 1'b1));
      chk("a5_valid_cycles", vcyc_n - v0, 1);

      // even parity: wrong then right parity bit
      send_frame(1, 8'h3C, 1, 1'b1, 1'b1);
      pop_check(1, "par_bad", {2'b01, 8'h3C});
      send_frame(1, 8'h3C, 1, 1'b0, 1'b1);
      pop_check(1, "par_ok", {2'b00, 8'h3C});

      // framing error, then a short glitch that must not start a frame
      send_frame(0, 8'h55, 0, 1'b0, 1'b0);
      pop_check(0, "frame_err", {2'b10, 8'h55});
      chk("after_ferr_empty", got_n.size(), 0);
      set_rx(0, 1'b0); wait_cyc(3); set_rx(0, 1'b1);
      wait_cyc(3 * CPB);
      chk("glitch_no_push", got_n.size(), 0);

      // break: 12 bit times low
      b0 = brk_cnt_n;
      set_rx(0, 1'b0); wait_cyc(12 * CPB); set_rx(0, 1'b1);
      wait_cyc(3 * CPB);
      chk("break_once", brk_cnt_n - b0, 1);
      chk("break_no_push", got_n.size(), 0);
      send_frame(0, 8'h81, 0, 1'b0, 1'b1);
      pop_check(0, "after_break", {2'b00, 8'h81});

      // overrun with a stalled consumer
      ready_n = 1'b0;
      o0 = ovr_cnt_n;
      for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 0, 1'b0, 1'b1);
      chk("full_no_ovr", ovr_cnt_n - o0, 0);
      chk("full_head_valid", valid_n, 1);
      chk("full_head_data", data_n, 8'h01);
      send_frame(0, 8'h05, 0, 1'b0, 1'b1);
      chk("ovr_pulse", ovr_cnt_n - o0, 1);
      ready_n = 1'b1;
      wait_cyc(10);
      for (int i = 1; i <= 4; i++) pop_check(0, $sformatf("drain%0d", i), {2'b00, 8'(i)});
      chk("drain_done", got_n.size(), 0);

      // reset in the middle of the data bits of 0x7E
      set_rx(0, 1'b0); wait_cyc(CPB);
      rd = 8'h7E;
      for (int i = 0; i < 4; i++) begin
         set_rx(0, rd[i]); wait_cyc(CPB);
      end
      set_rx(0, rd[4]); wait_cyc(CPB / 2);
      rst = 1'b1; wait_cyc(3); rst = 1'b0;
      set_rx(0, 1'b1); wait_cyc(3 * CPB);
      chk("midrst_no_push", got_n.size(), 0);
      chk("midrst_valid", valid_n, 0);
      send_frame(0, 8'h42, 0, 1'b0, 1'b1);
      pop_check(0, "after_rst", {2'b00, 8'h42});

      // randomized frames on the even-parity receiver
      brk_exp = brk_cnt_e;
      for (int k = 0; k < 12; k++) begin
         rd = 8'($urandom_range(0, 255));
         rp = 1'($urandom_range(0, 1));
         rs = ($urandom_range(0, 3) != 0);
         if (model_break(rd, 1, rp, rs)) brk_exp++;
         else exp_e.push_back(model_word(rd, 1, rp, rs));
         send_frame(1, rd, 1, rp, rs);
      end
      chk("rand_count", got_e.size(), exp_e.size());
      chk("rand_breaks", brk_cnt_e, brk_exp);
      while (exp_e.size() > 0) begin
         pop_check(1, $sformatf("rand%0d", exp_e.size()), exp_e.pop_front());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
